sram_req_arbiter: RTL and testbench

- Shares one downstream sram-like port (the AXI bridge's) between the instruction-fetch and data-access sram-like masters.
- Grants requests using data-first priority with an anti-starvation counter for fetch, and holds a grant stable until it is accepted.
- Records the owner of every accepted request in an in-order FIFO, so each data_ok/rdata response is returned to the correct master.
- Supports up to DEPTH outstanding transactions.

---
 rtl/sram_req_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Two-master arbiter onto one sram-like port: data-first priority with fetch
// anti-starvation, grant hold until accept, and an in-order owner FIFO for responses.
module sram_req_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    inst_req,
    input  logic                    inst_wr,
    input  logic [1:0]              inst_size,
    input  logic [31:0]             inst_addr,
    input  logic [3:0]              inst_wstrb,
    input  logic [31:0]             inst_wdata,
    output logic                    inst_addr_ok,
    output logic                    inst_data_ok,
    output logic [31:0]             inst_rdata,
    input  logic                    data_req,
    input  logic                    data_wr,
    input  logic [1:0]              data_size,
    input  logic [31:0]             data_addr,
    input  logic [3:0]              data_wstrb,
    input  logic [31:0]             data_wdata,
    output logic                    data_addr_ok,
    output logic                    data_data_ok,
    output logic [31:0]             data_rdata,
    output logic                    m_req,
    output logic                    m_wr,
    output logic [1:0]              m_size,
    output logic [31:0]             m_addr,
    output logic [3:0]              m_wstrb,
    output logic [31:0]             m_wdata,
    input  logic                    m_addr_ok,
    input  logic                    m_data_ok,
    input  logic [31:0]             m_rdata,
    output logic [$clog2(DEPTH):0]  outstanding,
    output logic                    proto_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        GRANT_FREE = 2'd0,
        HOLD_INST  = 2'd1,
        HOLD_DATA  = 2'd2
    } grant_state_e;

    grant_state_e      state_r;
    grant_state_e      state_nxt_s;
    logic              sel_data_s;
    logic              sel_req_s;
    logic              full_s;
    logic              empty_s;
    logic              acc_s;
    logic              pop_s;
    logic              head_s;
    logic [SW-1:0]     starve_r;
    logic [DEPTH-1:0]  owner_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              proto_err_r;

    assign full_s      = (count_r == CW'(DEPTH));
    assign empty_s     = (count_r == {CW{1'b0}});
    assign head_s      = owner_r[rd_ptr_r];
    assign outstanding = count_r;
    assign proto_err   = proto_err_r;
    assign inst_rdata  = m_rdata;
    assign data_rdata  = m_rdata;

    // Master selection: a held grant wins, else data first unless fetch has starved.
    always_comb begin
        sel_data_s = 1'b0;
        case (state_r)
            HOLD_INST: sel_data_s = 1'b0;
            HOLD_DATA: sel_data_s = 1'b1;
            default: begin
                if (inst_req && data_req) begin
                    sel_data_s = (starve_r != SW'(STARVE_MAX));
                end else begin
                    sel_data_s = data_req;
                end
            end
        endcase
    end

    // Downstream request, field mux and per-master handshakes.
    always_comb begin
        sel_req_s    = sel_data_s ? data_req : inst_req;
        m_req        = sel_req_s && !full_s && !areset;
        acc_s        = m_req && m_addr_ok;
        pop_s        = m_data_ok && !empty_s && !areset;
        inst_addr_ok = acc_s && !sel_data_s;
        data_addr_ok = acc_s && sel_data_s;
        inst_data_ok = pop_s && !head_s;
        data_data_ok = pop_s && head_s;
        if (sel_data_s) begin
            m_wr    = data_wr;
            m_size  = data_size;
            m_addr  = data_addr;
            m_wstrb = data_wstrb;
            m_wdata = data_wdata;
        end else begin
            m_wr    = inst_wr;
            m_size  = inst_size;
            m_addr  = inst_addr;
            m_wstrb = inst_wstrb;
            m_wdata = inst_wdata;
        end
    end

    // Grant-hold next state: latch a stalled grant, release on accept or when the holder withdraws.
    always_comb begin
        state_nxt_s = state_r;
        if (acc_s) begin
            state_nxt_s = GRANT_FREE;
        end else if (m_req) begin
            state_nxt_s = sel_data_s ? HOLD_DATA : HOLD_INST;
        end else begin
            case (state_r)
                HOLD_INST, HOLD_DATA: state_nxt_s = sel_req_s ? state_r : GRANT_FREE;
                default:              state_nxt_s = GRANT_FREE;
            endcase
        end
    end

    // Grant-hold state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r <= GRANT_FREE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fetch starvation counter, moves only on accepted requests.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            starve_r <= {SW{1'b0}};
        end else if (acc_s) begin
            if (sel_data_s && inst_req) begin
                if (starve_r != SW'(STARVE_MAX)) begin
                    starve_r <= starve_r + SW'(1'b1);
                end
            end else begin
                starve_r <= {SW{1'b0}};
            end
        end
    end

    // Owner FIFO, occupancy and sticky protocol error.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            owner_r     <= {DEPTH{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            proto_err_r <= 1'b0;
        end else begin
            if (acc_s) begin
                owner_r[wr_ptr_r] <= sel_data_s;
                wr_ptr_r          <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({acc_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
            if (m_data_ok && empty_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios plus random traffic, checked
// against a rule-level model with an owner scoreboard and a response monitor.
module tb_sram_req_arbiter;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

    logic        aclk = 1'b0;
    logic        areset = 1'b0;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, data_addr, inst_wdata, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        m_req, m_wr, m_addr_ok, m_data_ok;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [$clog2(DEPTH):0] outstanding;
    logic        proto_err;

    sram_req_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .aclk(aclk), .areset(areset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wstrb(m_wstrb),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .outstanding(outstanding), .proto_err(proto_err)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: owner queue is the scoreboard (0=inst, 1=data).
    int q[$];
    int dut_log[$];
    int starve_m = 0;
    int held_m = -1;
    int occ_m = 0;
    bit proto_m = 1'b0;
    bit acc_l = 1'b0, mreq_l = 1'b0, pop_l = 1'b0, err_l = 1'b0, rq_l = 1'b0, inst_req_l = 1'b0;
    int who_l = 0;

    // Grant prediction and comparison, sampled mid-cycle.
    always @(negedge aclk) begin : arb_check
        int who;
        bit rq, mreq, acc;
        if (areset) begin
            acc_l = 1'b0; mreq_l = 1'b0; pop_l = 1'b0; err_l = 1'b0;
        end else begin
            if (held_m >= 0) who = held_m;
            else if (inst_req && data_req) who = (starve_m == STARVE_MAX) ? 0 : 1;
            else if (data_req) who = 1;
            else who = 0;
            rq   = (who == 1) ? data_req : inst_req;
            mreq = rq && (occ_m < DEPTH);
            acc  = mreq && m_addr_ok;
            check("m_req", 32'(m_req), 32'(mreq));
            check("inst_addr_ok", 32'(inst_addr_ok), 32'(acc && who == 0));
            check("data_addr_ok", 32'(data_addr_ok), 32'(acc && who == 1));
            check("m_addr", m_addr, (who == 1) ? data_addr : inst_addr);
            check("m_wdata", m_wdata, (who == 1) ? data_wdata : inst_wdata);
            check("m_ctrl", 32'({m_wr, m_size, m_wstrb}),
                  (who == 1) ? 32'({data_wr, data_size, data_wstrb}) : 32'({inst_wr, inst_size, inst_wstrb}));
            if (data_addr_ok) dut_log.push_back(1);
            else if (inst_addr_ok) dut_log.push_back(0);
            acc_l = acc; mreq_l = mreq; rq_l = rq; who_l = who; inst_req_l = inst_req;
            pop_l = m_data_ok && (occ_m > 0);
            err_l = m_data_ok && (occ_m == 0);
        end
    end

    // Model state advance at the clock edge.
    always @(posedge aclk) begin : model_step
        if (areset) begin
            q.delete(); occ_m = 0; starve_m = 0; held_m = -1; proto_m = 1'b0;
        end else begin
            if (acc_l) begin
                q.push_back(who_l);
                held_m = -1;
                if (who_l == 1 && inst_req_l) starve_m = (starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX;
                else starve_m = 0;
            end else if (mreq_l) begin
                held_m = who_l;
            end else if (held_m >= 0 && !rq_l) begin
                held_m = -1;
            end
            occ_m = occ_m + (acc_l ? 1 : 0) - (pop_l ? 1 : 0);
            if (err_l) proto_m = 1'b1;
        end
    end

    // Response monitor: pops the scoreboard whenever a response is due.
    always @(negedge aclk) begin : resp_mon
        int e;
        if (areset) begin
            check("rst_outputs", 32'({m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
            check("rst_outstanding", 32'(outstanding), 32'd0);
            check("rst_proto_err", 32'(proto_err), 32'd0);
        end else begin
            check("outstanding", 32'(outstanding), 32'(q.size()));
            check("proto_err", 32'(proto_err), 32'(proto_m));
            if (m_data_ok && q.size() > 0) begin
                e = q.pop_front();
                check("resp_owner", 32'({inst_data_ok, data_data_ok}), (e == 1) ? 32'd1 : 32'd2);
                check("resp_rdata", (e == 1) ? data_rdata : inst_rdata, m_rdata);
            end else begin
                check("no_resp", 32'({inst_data_ok, data_data_ok}), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    endtask

    task automatic rand_fields();
        inst_wr = 1'($urandom); data_wr = 1'($urandom);
        inst_size = 2'($urandom); data_size = 2'($urandom);
        inst_addr = $urandom; data_addr = $urandom;
        inst_wstrb = 4'($urandom); data_wstrb = 4'($urandom);
        inst_wdata = $urandom; data_wdata = $urandom;
    endtask

    task automatic drain();
        idle();
        repeat (DEPTH + 2) begin
            m_data_ok = (q.size() > 0);
            m_rdata = $urandom;
            tick();
        end
        m_data_ok = 1'b0;
    endtask

    int exp_order[8] = '{1, 1, 1, 0, 1, 1, 1, 0};

    initial begin
        idle(); rand_fields(); m_rdata = 32'd0;
        #1 areset = 1'b1;
        repeat (3) tick();
        areset = 1'b0;

        // Single data read
        data_addr = 32'h1c00_0000; data_wr = 1'b0; data_req = 1'b1; m_addr_ok = 1'b1;
        #2 check("single_addr_ok", 32'(data_addr_ok), 32'd1);
        tick();
        check("single_outst1", 32'(outstanding), 32'd1);
        idle(); m_data_ok = 1'b1; m_rdata = 32'hdead_beef;
        #2 check("single_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd1);
        check("single_rdata", data_rdata, 32'hdead_beef);
        tick();
        m_data_ok = 1'b0;
        check("single_outst0", 32'(outstanding), 32'd0);

        // Both requesting continuously: anti-starvation pattern
        dut_log.delete();
        inst_req = 1'b1; data_req = 1'b1; m_addr_ok = 1'b1;
        repeat (8) begin
            rand_fields(); m_data_ok = (q.size() > 0); m_rdata = $urandom;
            tick();
        end
        check("order_count", 32'(dut_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < dut_log.size()) check("grant_order", 32'(dut_log[i]), 32'(exp_order[i]));
        end
        drain();

        // Grant hold while the downstream stalls
        inst_req = 1'b1; m_addr_ok = 1'b0;
        repeat (3) tick();
        data_req = 1'b1;
        tick();
        m_addr_ok = 1'b1;
        #2 check("hold_inst_ok", 32'(inst_addr_ok), 32'd1);
        check("hold_m_addr", m_addr, inst_addr);
        tick();
        inst_req = 1'b0;
        #2 check("hold_data_next", 32'(data_addr_ok), 32'd1);
        tick();
        drain();

        // Fill to DEPTH, no bypass on a same-cycle pop
        rand_fields(); data_req = 1'b1; m_addr_ok = 1'b1;
        repeat (DEPTH) tick();
        #2 check("fill_outst", 32'(outstanding), 32'(DEPTH));
        check("fill_mreq", 32'(m_req), 32'd0);
        m_data_ok = 1'b1;
        #1 check("fill_no_bypass", 32'(data_addr_ok), 32'd0);
        tick();
        m_data_ok = 1'b0;
        #2 check("fill_accept", 32'(data_addr_ok), 32'd1);
        tick();
        check("fill_outst_again", 32'(outstanding), 32'(DEPTH));
        drain();

        // In-order response routing across pointer wrap
        repeat (10) begin
            rand_fields();
            inst_req = 1'b1; m_addr_ok = 1'b1; tick();
            inst_req = 1'b0; data_req = 1'b1; tick();
            data_req = 1'b0; inst_req = 1'b1; tick();
            idle();
            repeat (3) begin
                m_data_ok = 1'b1; m_rdata = $urandom; tick();
            end
            m_data_ok = 1'b0;
        end

        // Random traffic
        repeat (3000) begin
            rand_fields();
            inst_req = ($urandom_range(0, 99) < 60);
            data_req = ($urandom_range(0, 99) < 60);
            m_addr_ok = ($urandom_range(0, 99) < 50);
            m_data_ok = (q.size() > 0) && ($urandom_range(0, 99) < 45);
            m_rdata = $urandom;
            tick();
        end
        drain();

        // Response with nothing outstanding
        m_data_ok = 1'b1;
        #2 check("err_no_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        tick();
        m_data_ok = 1'b0;
        check("err_sticky", 32'(proto_err), 32'd1);
        tick();

        // Reset mid-stream with two outstanding
        data_req = 1'b1; m_addr_ok = 1'b1;
        repeat (2) tick();
        areset = 1'b1;
        #1 check("rst_mid_outst", 32'(outstanding), 32'd0);
        check("rst_mid_proto", 32'(proto_err), 32'd0);
        check("rst_mid_mreq", 32'(m_req), 32'd0);
        tick(); tick();
        areset = 1'b0;
        idle();
        tick();
        m_data_ok = 1'b1;
        tick();
        m_data_ok = 1'b0;
        check("post_rst_err", 32'(proto_err), 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
